apb_arbiter_2to1: RTL and testbench

- Shares one downstream APB port between two upstream APB masters (m0: instruction fetch, m1: load/store) in front of the APB delayer and peripheral crossbar.
- Arbitrates round-robin and regenerates clean SETUP/ACCESS phases downstream.
- Returns the completion only to the granted master.
- A programmable watchdog aborts downstream transfers that never complete, returning pslverr.

---
 rtl/apb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 18 +
 rtl/apb_arbiter_2to1.sv | 157 +++++++++++++++
 tb/tb_apb_arbiter_2to1.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the transfer phase encoding.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;
   localparam int unsigned APB_PROT_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins; on a tie the master that did
// not win last time wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_c
);

   always_comb begin
      grant_c = 1'b0;
      if (req == 2'b11) begin
         grant_c = ~last_grant;
      end else begin
         grant_c = req[1];
      end
   end

endmodule

// File: rtl/apb_arbiter_2to1.sv
// Shares one downstream APB port between two masters with round-robin
// arbitration, regenerated SETUP/ACCESS phases and an ACCESS-phase watchdog.
module apb_arbiter_2to1
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W  = APB_ADDR_W,
   parameter int unsigned DATA_W  = APB_DATA_W,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic [ADDR_W-1:0]     m0_paddr,
   input  logic                  m0_psel,
   input  logic                  m0_penable,
   input  logic [APB_PROT_W-1:0] m0_pprot,
   input  logic                  m0_pwrite,
   input  logic [DATA_W-1:0]     m0_pwdata,
   input  logic [DATA_W/8-1:0]   m0_pstrb,
   output logic                  m0_pready,
   output logic [DATA_W-1:0]     m0_prdata,
   output logic                  m0_pslverr,

   input  logic [ADDR_W-1:0]     m1_paddr,
   input  logic                  m1_psel,
   input  logic                  m1_penable,
   input  logic [APB_PROT_W-1:0] m1_pprot,
   input  logic                  m1_pwrite,
   input  logic [DATA_W-1:0]     m1_pwdata,
   input  logic [DATA_W/8-1:0]   m1_pstrb,
   output logic                  m1_pready,
   output logic [DATA_W-1:0]     m1_prdata,
   output logic                  m1_pslverr,

   output logic [ADDR_W-1:0]     out_paddr,
   output logic                  out_psel,
   output logic                  out_penable,
   output logic [APB_PROT_W-1:0] out_pprot,
   output logic                  out_pwrite,
   output logic [DATA_W-1:0]     out_pwdata,
   output logic [DATA_W/8-1:0]   out_pstrb,
   input  logic                  out_pready,
   input  logic [DATA_W-1:0]     out_prdata,
   input  logic                  out_pslverr
);

   localparam int unsigned WD_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit          WD_EN   = (TIMEOUT != 0);
   localparam int unsigned WD_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   apb_state_e        state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

   logic              pick_c;
   logic              active_c;
   logic              done_c;
   logic              abort_c;
   logic              unused_penable;

   // Phases are regenerated locally, so upstream penable carries no information.
   assign unused_penable = m0_penable ^ m1_penable;

   rr_arb2 u_rr_arb2 (
      .req        ({m1_psel, m0_psel}),
      .last_grant (last_grant_q),
      .grant_c    (pick_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         wd_cnt_q     <= wd_cnt_d;
      end
   end

   // Next-state, watchdog and completion detection.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      wd_cnt_d     = wd_cnt_q;
      done_c       = 1'b0;
      abort_c      = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_psel || m1_psel) begin
               grant_d = pick_c;
               state_d = SETUP;
            end
         end
         SETUP: begin
            wd_cnt_d = '0;
            state_d  = ACCESS;
         end
         ACCESS: begin
            if (out_pready) begin
               done_c       = 1'b1;
               last_grant_d = grant_q;
               state_d      = IDLE;
            end else if (WD_EN && (wd_cnt_q == WD_W'(WD_LAST))) begin
               abort_c      = 1'b1;
               last_grant_d = grant_q;
               state_d      = IDLE;
            end else if (wd_cnt_q != '1) begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Downstream request mux and completion return; everything quiet under reset.
   always_comb begin
      active_c    = (state_q != IDLE) && !reset;
      out_psel    = active_c;
      out_penable = active_c && (state_q == ACCESS);
      out_paddr   = '0;
      out_pprot   = '0;
      out_pwrite  = 1'b0;
      out_pwdata  = '0;
      out_pstrb   = '0;
      m0_pready   = 1'b0;
      m0_prdata   = '0;
      m0_pslverr  = 1'b0;
      m1_pready   = 1'b0;
      m1_prdata   = '0;
      m1_pslverr  = 1'b0;
      if (active_c) begin
         out_paddr  = grant_q ? m1_paddr  : m0_paddr;
         out_pprot  = grant_q ? m1_pprot  : m0_pprot;
         out_pwrite = grant_q ? m1_pwrite : m0_pwrite;
         out_pwdata = grant_q ? m1_pwdata : m0_pwdata;
         out_pstrb  = grant_q ? m1_pstrb  : m0_pstrb;
      end
      if (!reset && (done_c || abort_c)) begin
         if (grant_q) begin
            m1_pready  = 1'b1;
            m1_prdata  = done_c ? out_prdata : '0;
            m1_pslverr = done_c ? out_pslverr : 1'b1;
         end else begin
            m0_pready  = 1'b1;
            m0_prdata  = done_c ? out_prdata : '0;
            m0_pslverr = done_c ? out_pslverr : 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_arbiter_2to1.sv
// Directed bench for apb_arbiter_2to1: per-cycle vector table plus hand-written
// wait-state, watchdog and reset-during-transfer sequences.
module tb_apb_arbiter_2to1;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam logic [31:0] A0 = 32'h0000_1000;
   localparam logic [31:0] A1 = 32'h1000_0004;
   localparam logic [31:0] RD = 32'hDEAD_BEEF;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] m0_paddr, m1_paddr, out_paddr;
   logic          m0_psel, m1_psel, m0_penable, m1_penable;
   logic [2:0]    m0_pprot, m1_pprot, out_pprot;
   logic          m0_pwrite, m1_pwrite, out_pwrite;
   logic [DW-1:0] m0_pwdata, m1_pwdata, out_pwdata;
   logic [3:0]    m0_pstrb, m1_pstrb, out_pstrb;
   logic          m0_pready, m1_pready, m0_pslverr, m1_pslverr;
   logic [DW-1:0] m0_prdata, m1_prdata, out_prdata;
   logic          out_psel, out_penable, out_pready, out_pslverr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst, p0, p1, rdy, err;
      logic        e_psel, e_pen;
      logic [31:0] e_addr;
      logic        e_r0, e_r1, e_err0, e_err1;
      logic [31:0] e_rd0, e_rd1;
   } vec_t;

   vec_t tbl [18];

   always #5 clock = ~clock;

   apb_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
      .clock(clock), .reset(reset),
      .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pprot(m0_pprot),
      .m0_pwrite(m0_pwrite), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
      .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
      .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pprot(m1_pprot),
      .m1_pwrite(m1_pwrite), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
      .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
      .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
      .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
      .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
      .out_pslverr(out_pslverr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: inputs change just after the rising edge, checks follow after settling.
   task automatic apply(input logic rst, input logic p0, input logic p1,
                        input logic rdy, input logic err);
      @(posedge clock);
      #1;
      reset       = rst;
      m0_psel     = p0;
      m0_penable  = p0;
      m1_psel     = p1;
      m1_penable  = p1;
      out_pready  = rdy;
      out_pslverr = err;
      #2;
   endtask

   initial begin
      int pulses;
      reset = 1'b1;
      m0_paddr = A0; m0_psel = 1'b0; m0_penable = 1'b0; m0_pprot = 3'b010;
      m0_pwrite = 1'b0; m0_pwdata = 32'hAAAA_5555; m0_pstrb = 4'h3;
      m1_paddr = A1; m1_psel = 1'b0; m1_penable = 1'b0; m1_pprot = 3'b101;
      m1_pwrite = 1'b1; m1_pwdata = 32'h1234_5678; m1_pstrb = 4'hF;
      out_pready = 1'b0; out_prdata = RD; out_pslverr = 1'b0;

      //          rst p0 p1 rdy err psel pen addr  r0 r1 e0 e1 rd0 rd1
      tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0};
      tbl[1]  = '{0, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0};
      tbl[2]  = '{0, 1, 0, 0, 0,  1, 0, A0,  0, 0, 0, 0, 0,  0};
      tbl[3]  = '{0, 1, 0, 1, 0,  1, 1, A0,  1, 0, 0, 0, RD, 0};
      tbl[4]  = '{1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0};
      tbl[5]  = '{0, 1, 1, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0};
      tbl[6]  = '{0, 1, 1, 0, 0,  1, 0, A0,  0, 0, 0, 0, 0,  0};
      tbl[7]  = '{0, 1, 1, 1, 0,  1, 1, A0,  1, 0, 0, 0, RD, 0};
      tbl[8]  = '{0, 1, 1, 1, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0};
      tbl[9]  = '{0, 1, 1, 0, 0,  1, 0, A1,  0, 0, 0, 0, 0,  0};
      tbl[10] = '{0, 1, 1, 1, 0,  1, 1, A1,  0, 1, 0, 0, 0,  RD};
      tbl[11] = '{0, 1, 1, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0};
      tbl[12] = '{0, 1, 1, 1, 0,  1, 0, A0,  0, 0, 0, 0, 0,  0};
      tbl[13] = '{0, 1, 1, 1, 1,  1, 1, A0,  1, 0, 1, 0, RD, 0};
      tbl[14] = '{0, 1, 1, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0};
      tbl[15] = '{0, 1, 1, 0, 0,  1, 0, A1,  0, 0, 0, 0, 0,  0};
      tbl[16] = '{0, 1, 1, 1, 0,  1, 1, A1,  0, 1, 0, 0, 0,  RD};
      tbl[17] = '{0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0};

      repeat (2) @(posedge clock);

      for (int i = 0; i < 18; i++) begin
         apply(tbl[i].rst, tbl[i].p0, tbl[i].p1, tbl[i].rdy, tbl[i].err);
         chk($sformatf("v%0d psel", i),    32'(out_psel),    32'(tbl[i].e_psel));
         chk($sformatf("v%0d penable", i), 32'(out_penable), 32'(tbl[i].e_pen));
         chk($sformatf("v%0d paddr", i),   out_paddr,        tbl[i].e_addr);
         chk($sformatf("v%0d m0_pready", i),  32'(m0_pready),  32'(tbl[i].e_r0));
         chk($sformatf("v%0d m1_pready", i),  32'(m1_pready),  32'(tbl[i].e_r1));
         chk($sformatf("v%0d m0_pslverr", i), 32'(m0_pslverr), 32'(tbl[i].e_err0));
         chk($sformatf("v%0d m1_pslverr", i), 32'(m1_pslverr), 32'(tbl[i].e_err1));
         chk($sformatf("v%0d m0_prdata", i),  m0_prdata,       tbl[i].e_rd0);
         chk($sformatf("v%0d m1_prdata", i),  m1_prdata,       tbl[i].e_rd1);
      end

      // m1 write with five wait states: request must stay stable, one pready pulse.
      pulses = 0;
      apply(0, 0, 1, 0, 0);
      chk("wr idle psel", 32'(out_psel), 32'd0);
      apply(0, 0, 1, 0, 0);
      chk("wr setup psel", 32'(out_psel), 32'd1);
      chk("wr setup penable", 32'(out_penable), 32'd0);
      for (int c = 1; c <= 6; c++) begin
         apply(0, 0, 1, (c == 6), 0);
         chk($sformatf("wr acc%0d psel", c),    32'(out_psel),    32'd1);
         chk($sformatf("wr acc%0d penable", c), 32'(out_penable), 32'd1);
         chk($sformatf("wr acc%0d paddr", c),   out_paddr,        A1);
         chk($sformatf("wr acc%0d pwdata", c),  out_pwdata,       32'h1234_5678);
         chk($sformatf("wr acc%0d pwrite", c),  32'(out_pwrite),  32'd1);
         chk($sformatf("wr acc%0d pstrb", c),   32'(out_pstrb),   32'hF);
         chk($sformatf("wr acc%0d pprot", c),   32'(out_pprot),   32'h5);
         chk($sformatf("wr acc%0d m1_pready", c), 32'(m1_pready), 32'(c == 6));
         chk($sformatf("wr acc%0d m0_pready", c), 32'(m0_pready), 32'd0);
         if (m1_pready) pulses++;
      end
      apply(0, 0, 0, 0, 0);
      chk("wr after psel", 32'(out_psel), 32'd0);
      chk("wr after m1_pready", 32'(m1_pready), 32'd0);
      chk("wr pulse count", 32'(pulses), 32'd1);

      // m0 read that never completes: watchdog aborts on the eighth ACCESS cycle.
      apply(0, 1, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      chk("to setup psel", 32'(out_psel), 32'd1);
      for (int c = 1; c <= 8; c++) begin
         apply(0, 1, 0, 0, 0);
         chk($sformatf("to acc%0d psel", c),      32'(out_psel),   32'd1);
         chk($sformatf("to acc%0d m0_pready", c), 32'(m0_pready),  32'(c == 8));
         chk($sformatf("to acc%0d m0_pslverr", c), 32'(m0_pslverr), 32'(c == 8));
         chk($sformatf("to acc%0d m0_prdata", c), m0_prdata,       32'd0);
         chk($sformatf("to acc%0d m1_pready", c), 32'(m1_pready),  32'd0);
      end
      apply(0, 0, 0, 0, 0);
      chk("to after psel", 32'(out_psel), 32'd0);
      for (int c = 0; c < 2; c++) begin
         apply(0, 0, 0, 1, 0);
         chk($sformatf("to stray%0d m0_pready", c), 32'(m0_pready), 32'd0);
         chk($sformatf("to stray%0d m1_pready", c), 32'(m1_pready), 32'd0);
         chk($sformatf("to stray%0d psel", c),      32'(out_psel),  32'd0);
      end

      // Reset raised while m1 is in ACCESS, then a tie afterwards goes to m0.
      apply(0, 0, 1, 0, 0);
      apply(0, 0, 1, 0, 0);
      apply(0, 0, 1, 0, 0);
      chk("rst acc psel", 32'(out_psel), 32'd1);
      chk("rst acc penable", 32'(out_penable), 32'd1);
      chk("rst acc paddr", out_paddr, A1);
      apply(1, 0, 1, 0, 0);
      chk("rst cycle m1_pready", 32'(m1_pready), 32'd0);
      apply(0, 1, 1, 1, 0);
      chk("rst next psel", 32'(out_psel), 32'd0);
      chk("rst next m1_pready", 32'(m1_pready), 32'd0);
      chk("rst next m0_pready", 32'(m0_pready), 32'd0);
      apply(0, 1, 1, 0, 0);
      chk("rst tie psel", 32'(out_psel), 32'd1);
      chk("rst tie paddr", out_paddr, A0);
      apply(0, 1, 1, 1, 0);
      chk("rst tie m0_pready", 32'(m0_pready), 32'd1);
      chk("rst tie m0_prdata", m0_prdata, RD);
      chk("rst tie m1_pready", 32'(m1_pready), 32'd0);
      apply(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
